// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon memory-game engine.
//   state_t      : top-level game states
//   LFSR_TAPS    : Galois feedback mask for the 16-bit symbol generator
//   DEFAULT_SEED : seed used when the free-running counter happens to be zero
//   lfsr_next()  : one Galois step (right shift, XOR taps when bit 0 falls out)
package simon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_PAUSE,
        ST_INPUT,
        ST_WIN,
        ST_LOST
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit Galois LFSR that regenerates the game's symbol sequence.
//   clk, rst_n : clock, synchronous active-low reset
//   load, seed : restart the sequence from seed (wins over step)
//   step       : advance one symbol
//   state      : current LFSR contents; low bits form the symbol
module simon_lfsr
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= DEFAULT_SEED;
        else if (load)
            state <= seed;
        else if (step)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/simon_engine.sv
// Simon memory-game engine. Plays back a growing pseudo-random sequence on the
// LEDs, then checks the player's echo. The sequence is never stored: it is
// regenerated from the seed captured at game start.
//   clk, rst_n : clock, synchronous active-low reset
//   tick       : timing strobe; all tick timers advance only when high
//   key_press  : one-cycle press pulses (one bit per key)
//   led        : key LEDs
//   score      : rounds completed in the current/last game
//   high_score : best score since reset
//   won, lost  : high while in WIN / LOST
module simon_engine
    import simon_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int MAX_LEN       = 32,
    parameter int ON_TICKS      = 400,
    parameter int OFF_TICKS     = 200,
    parameter int TIMEOUT_TICKS = 3000,
    parameter int END_TICKS     = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] led,
    output logic [7:0]          score,
    output logic [7:0]          high_score,
    output logic                won,
    output logic                lost
);

    localparam int          SYM_W   = $clog2(NUM_KEYS);
    localparam logic [15:0] ON_LAST  = 16'(ON_TICKS - 1);
    localparam logic [15:0] OFF_LAST = 16'(OFF_TICKS - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_TICKS - 1);
    localparam logic [15:0] END_LAST = 16'(END_TICKS - 1);
    localparam logic [7:0]  LEN_MAX  = 8'(MAX_LEN);

    state_t      state;
    logic [15:0] counter;
    logic [15:0] seed;
    logic [15:0] timer;
    logic [7:0]  len;
    logic [7:0]  idx;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_seed;
    logic        lfsr_load;
    logic        lfsr_step;

    function automatic logic [NUM_KEYS-1:0] onehot(input logic [15:0] s);
        onehot = {{(NUM_KEYS-1){1'b0}}, 1'b1} << s[SYM_W-1:0];
    endfunction

    logic [15:0]         start_seed;
    logic [NUM_KEYS-1:0] exp_key;
    logic                press_any;
    logic                accept;
    logic                is_last;
    logic                on_done;
    logic                off_done;
    logic                to_done;
    logic                end_done;

    // A zero seed would lock the LFSR, so substitute the default.
    assign start_seed = (counter == 16'd0) ? DEFAULT_SEED : counter;
    assign exp_key    = onehot(lfsr_q);
    assign press_any  = |key_press;
    // exp_key is one-hot, so equality also rejects multi-key presses.
    assign accept     = (state == ST_INPUT) && press_any && (key_press == exp_key);
    assign is_last    = (idx == len - 8'd1);
    assign on_done    = tick && (timer == ON_LAST);
    assign off_done   = tick && (timer == OFF_LAST);
    assign to_done    = tick && (timer == TO_LAST);
    assign end_done   = tick && (timer == END_LAST);

    // LFSR controls are decoded from the same conditions the FSM acts on, so
    // the generator moves on the same edge as the state.
    assign lfsr_load = ((state == ST_IDLE) && press_any)
                    || ((state == ST_SHOW_OFF) && off_done && is_last)
                    || (accept && is_last);
    assign lfsr_step = ((state == ST_SHOW_OFF) && off_done && !is_last)
                    || (accept && !is_last);
    assign lfsr_seed = (state == ST_IDLE) ? start_seed : seed;

    simon_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (lfsr_seed),
        .state (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            counter    <= 16'd0;
            seed       <= 16'd0;
            timer      <= 16'd0;
            len        <= 8'd0;
            idx        <= 8'd0;
            led        <= '0;
            score      <= 8'd0;
            high_score <= 8'd0;
            won        <= 1'b0;
            lost       <= 1'b0;
        end else begin
            counter <= counter + 16'd1;
            case (state)
                ST_IDLE: begin
                    led <= '0;
                    if (press_any) begin
                        seed  <= start_seed;
                        len   <= 8'd1;
                        idx   <= 8'd0;
                        score <= 8'd0;
                        timer <= 16'd0;
                        // First symbol comes straight from the new seed.
                        led   <= onehot(start_seed);
                        state <= ST_SHOW_ON;
                    end
                end
                ST_SHOW_ON: begin
                    if (tick) begin
                        if (on_done) begin
                            timer <= 16'd0;
                            led   <= '0;
                            state <= ST_SHOW_OFF;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                ST_SHOW_OFF: begin
                    if (tick) begin
                        if (off_done) begin
                            timer <= 16'd0;
                            if (is_last) begin
                                idx   <= 8'd0;
                                state <= ST_INPUT;
                            end else begin
                                idx   <= idx + 8'd1;
                                // LFSR steps on this edge; show the symbol it steps to.
                                led   <= onehot(lfsr_next(lfsr_q));
                                state <= ST_SHOW_ON;
                            end
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (tick) begin
                        if (off_done) begin
                            timer <= 16'd0;
                            // LFSR was already reloaded when the round completed.
                            led   <= onehot(lfsr_q);
                            state <= ST_SHOW_ON;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                ST_INPUT: begin
                    led <= '0;
                    // Press handling comes first so an accepted press beats a
                    // timeout landing on the same cycle.
                    if (accept) begin
                        timer <= 16'd0;
                        if (is_last) begin
                            score <= len;
                            if (len == LEN_MAX) begin
                                won        <= 1'b1;
                                led        <= '1;
                                high_score <= (len > high_score) ? len : high_score;
                                state      <= ST_WIN;
                            end else begin
                                len   <= len + 8'd1;
                                idx   <= 8'd0;
                                state <= ST_PAUSE;
                            end
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end else if (press_any || to_done) begin
                        timer      <= 16'd0;
                        lost       <= 1'b1;
                        high_score <= (score > high_score) ? score : high_score;
                        state      <= ST_LOST;
                    end else if (tick) begin
                        timer <= timer + 16'd1;
                    end
                end
                ST_WIN, ST_LOST: begin
                    if (tick) begin
                        if (end_done) begin
                            timer <= 16'd0;
                            won   <= 1'b0;
                            lost  <= 1'b0;
                            led   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                default: begin
                    led   <= '0;
                    won   <= 1'b0;
                    lost  <= 1'b0;
                    timer <= 16'd0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_engine.sv
// Directed/randomised bench for simon_engine with a small game model:
// symbols come from the seed (cycles since reset release at the start press)
// through the Galois rule, timing from the tick parameters.
module tb_simon_engine;

    localparam int NK   = 4;
    localparam int MAXL = 3;
    localparam int ON_T = 2;
    localparam int OFF_T = 1;
    localparam int TO_T = 5;
    localparam int END_T = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic [NK-1:0] key_press;
    logic [NK-1:0] led;
    logic [7:0]    score;
    logic [7:0]    high_score;
    logic          won;
    logic          lost;

    simon_engine #(
        .NUM_KEYS      (NK),
        .MAX_LEN       (MAXL),
        .ON_TICKS      (ON_T),
        .OFF_TICKS     (OFF_T),
        .TIMEOUT_TICKS (TO_T),
        .END_TICKS     (END_T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .key_press  (key_press),
        .led        (led),
        .score      (score),
        .high_score (high_score),
        .won        (won),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] cnt   = 16'd0;   // cycles since reset release
    logic [1:0]  syms [MAXL];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        logic r;
        r = rst_n;
        @(posedge clk);
        #1;
        cnt = r ? cnt + 16'd1 : 16'd0;
    endtask

    function automatic logic [NK-1:0] key_of(input logic [1:0] s);
        logic [NK-1:0] one;
        one = 1;
        return one << s;
    endfunction

    function automatic logic [15:0] model_next(input logic [15:0] s);
        return (s >> 1) ^ (((s & 16'd1) != 16'd0) ? 16'hB400 : 16'h0000);
    endfunction

    task automatic press(input logic [NK-1:0] k);
        key_press = k;
        cyc();
        key_press = '0;
    endtask

    task automatic start_game();
        logic [15:0] s;
        repeat ($urandom_range(0, 15)) cyc();
        s = (cnt == 16'd0) ? 16'hACE1 : cnt;
        for (int i = 0; i < MAXL; i++) begin
            syms[i] = 2'(s % 16'd4);
            s = model_next(s);
        end
        press(NK'($urandom_range(1, (1 << NK) - 1)));
    endtask

    // Checks the LED playback of a round; ends on the first INPUT cycle.
    task automatic play_round(input int l, input bit noisy);
        for (int i = 0; i < l; i++) begin
            for (int t = 0; t < ON_T; t++) begin
                chk($sformatf("show_on r%0d s%0d", l, i), 16'(led), 16'(key_of(syms[i])));
                if (noisy) key_press = NK'($urandom);
                cyc();
            end
            for (int t = 0; t < OFF_T; t++) begin
                chk($sformatf("show_off r%0d s%0d", l, i), 16'(led), 16'd0);
                if (noisy) key_press = NK'($urandom);
                cyc();
            end
        end
        key_press = '0;
    endtask

    // Full correct non-final round; ends on the first SHOW_ON cycle of the next.
    task automatic round_ok(input int l, input bit noisy);
        play_round(l, noisy);
        for (int j = 0; j < l; j++) press(key_of(syms[j]));
        chk($sformatf("score after r%0d", l), 16'(score), 16'(l));
        chk($sformatf("pause led r%0d", l), 16'(led), 16'd0);
        chk($sformatf("no loss r%0d", l), 16'(lost), 16'd0);
        cyc();
    endtask

    task automatic end_phase(input bit is_win);
        for (int t = 0; t < END_T; t++) begin
            chk("end won", 16'(won), 16'(is_win));
            chk("end lost", 16'(lost), 16'(!is_win));
            chk("end led", 16'(led), is_win ? 16'hF : 16'h0);
            key_press = NK'($urandom);
            cyc();
        end
        key_press = '0;
        chk("idle won", 16'(won), 16'd0);
        chk("idle lost", 16'(lost), 16'd0);
        chk("idle led", 16'(led), 16'd0);
    endtask

    task automatic wrong_press(input int l);
        int j;
        logic [1:0] w;
        j = $urandom_range(0, l - 1);
        for (int k = 0; k < j; k++) press(key_of(syms[k]));
        w = syms[j] + 2'($urandom_range(1, 3));
        press(key_of(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick      = 1'b1;
        rst_n     = 1'b0;
        key_press = 4'b0001;
        repeat (3) cyc();
        chk("rst led", 16'(led), 16'd0);
        chk("rst score", 16'(score), 16'd0);
        chk("rst high", 16'(high_score), 16'd0);
        chk("rst won", 16'(won), 16'd0);
        chk("rst lost", 16'(lost), 16'd0);
        rst_n     = 1'b1;
        key_press = '0;
        for (int t = 0; t < 3; t++) begin
            cyc();
            chk("idle after rst", 16'(led), 16'd0);
        end

        // Game A: round 1 right, round 2 wrong.
        start_game();
        round_ok(1, 1'b0);
        play_round(2, 1'b0);
        wrong_press(2);
        chk("A lost", 16'(lost), 16'd1);
        chk("A score", 16'(score), 16'd1);
        chk("A high", 16'(high_score), 16'd1);
        end_phase(1'b0);
        chk("A score held", 16'(score), 16'd1);

        // Game B: two rounds, wrong in round 3.
        start_game();
        round_ok(1, 1'b0);
        round_ok(2, 1'b0);
        play_round(3, 1'b0);
        wrong_press(3);
        chk("B lost", 16'(lost), 16'd1);
        chk("B score", 16'(score), 16'd2);
        chk("B high", 16'(high_score), 16'd2);
        end_phase(1'b0);

        // Game C: timeout in round 1.
        start_game();
        play_round(1, 1'b0);
        for (int t = 0; t < TO_T - 1; t++) begin
            cyc();
            chk("C waiting", 16'(lost), 16'd0);
        end
        cyc();
        chk("C timeout", 16'(lost), 16'd1);
        chk("C score", 16'(score), 16'd0);
        chk("C high kept", 16'(high_score), 16'd2);
        end_phase(1'b0);

        // Game D: press on the expiry cycle, then multi-key press.
        start_game();
        play_round(1, 1'b0);
        repeat (TO_T - 1) cyc();
        press(key_of(syms[0]));
        chk("D expiry accept", 16'(lost), 16'd0);
        chk("D score", 16'(score), 16'd1);
        cyc();
        play_round(2, 1'b0);
        press(4'b0011);
        chk("D multi lost", 16'(lost), 16'd1);
        chk("D multi score", 16'(score), 16'd1);
        end_phase(1'b0);

        // Game E: win with noise on the keys during playback/end.
        start_game();
        round_ok(1, 1'b1);
        round_ok(2, 1'b1);
        play_round(3, 1'b1);
        for (int j = 0; j < MAXL; j++) press(key_of(syms[j]));
        chk("E won", 16'(won), 16'd1);
        chk("E score", 16'(score), 16'd3);
        chk("E high", 16'(high_score), 16'd3);
        end_phase(1'b1);
        chk("E score held", 16'(score), 16'd3);
        chk("E high held", 16'(high_score), 16'd3);

        // Game F: reset during SHOW_ON after scoring 2.
        start_game();
        round_ok(1, 1'b0);
        round_ok(2, 1'b0);
        chk("F show_on", 16'(led), 16'(key_of(syms[0])));
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("F rst led", 16'(led), 16'd0);
        chk("F rst score", 16'(score), 16'd0);
        chk("F rst high", 16'(high_score), 16'd0);
        for (int t = 0; t < 3; t++) begin
            cyc();
            chk("F idle", 16'(led), 16'd0);
        end
        start_game();
        play_round(1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simon_engine.md
SIMON_ENGINE -- requirements
Module: simon_engine

Interface
REQ-001 Parameter NUM_KEYS, 4, number of key/LED channels; SHALL be a power of two, 2..8.
REQ-002 Parameter MAX_LEN, 32, sequence length that wins the game; SHALL be 1..255.
REQ-003 Parameter ON_TICKS, 400, ticks each LED is lit during playback.
REQ-004 Parameter OFF_TICKS, 200, ticks of dark gap between playback steps and before each new round.
REQ-005 Parameter TIMEOUT_TICKS, 3000, maximum ticks allowed between accepted presses in INPUT.
REQ-006 Parameter END_TICKS, 1000, ticks spent in WIN/LOST before returning to IDLE.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 tick  in  1  one-cycle timing strobe; all tick-based timers advance only when tick=1.
REQ-010 key_press  in  NUM_KEYS  one-cycle press pulses, already synchronised and debounced upstream.
REQ-011 led  out  NUM_KEYS  key LEDs.
REQ-012 score  out  8  rounds completed in the current or last game.
REQ-013 high_score  out  8  best score since reset.
REQ-014 won  out  1  high while in WIN.
REQ-015 lost  out  1  high while in LOST.

Function
REQ-016 States SHALL be IDLE, SHOW_ON, SHOW_OFF, PAUSE, INPUT, WIN, LOST; all outputs registered.
REQ-017 A 16-bit free-running counter SHALL increment every clk; the symbol sequence SHALL be regenerated from a stored seed, with no sequence memory.
REQ-018 Symbol = low log2(NUM_KEYS) bits of the LFSR state; LFSR steps once per symbol consumed.
REQ-019 IDLE: led=0; any nonzero key_press -> seed := counter (16'hACE1 if counter is 0), LFSR loaded with seed, len:=1, idx:=0, score:=0, go SHOW_ON.
REQ-020 SHOW_ON: led=onehot(symbol); after ON_TICKS ticks -> SHOW_OFF, led=0.
REQ-021 SHOW_OFF: after OFF_TICKS ticks -> if idx==len-1 then reload LFSR with seed, idx:=0, timer:=0, go INPUT; else step LFSR, idx+1, go SHOW_ON.
REQ-022 INPUT: led=0; key_press==0 -> no action; timer counts ticks since entry or last accepted press.
REQ-023 INPUT: single-bit key_press equal to onehot(symbol) -> accepted: timer:=0, step LFSR; if idx<len-1 then idx+1.
REQ-024 Accepted press with idx==len-1 -> score:=len; if len==MAX_LEN go WIN; else len+1, idx:=0, reload LFSR with seed, go PAUSE.
REQ-025 PAUSE: led=0; after OFF_TICKS ticks -> SHOW_ON.
REQ-026 INPUT: multi-bit or wrong-key press -> LOST; timer reaching TIMEOUT_TICKS -> LOST.
REQ-027 An accepted press in the same cycle as timeout expiry SHALL take precedence over the timeout.
REQ-028 On entry to WIN or LOST, high_score := max(high_score, score), registered in the entry cycle.
REQ-029 WIN: led=all ones, won=1; LOST: led=0, lost=1; after END_TICKS ticks -> IDLE; key_press ignored.
REQ-030 key_press SHALL be ignored in SHOW_ON, SHOW_OFF and PAUSE.
REQ-031 score and high_score SHALL hold value through IDLE; score clears only at game start.

Reset
REQ-032 rst_n=0 at a clk edge -> state IDLE, led=0, score=0, high_score=0, won=0, lost=0, all timers/idx/len cleared, in any state including mid-playback.
REQ-033 Presses during reset SHALL be discarded; the first press after release starts a game.

Structure
REQ-034 Package simon_pkg SHALL hold the state enum, LFSR tap constant (16'hB400, Galois) and default seed 16'hACE1.
REQ-035 Sub-module simon_lfsr SHALL implement the 16-bit Galois LFSR with load and step controls.

Verification (NUM_KEYS=4, MAX_LEN=3, ON_TICKS=2, OFF_TICKS=1, TIMEOUT_TICKS=5, END_TICKS=2, tick=1 every cycle)
REQ-036 rst_n=0 for 3 cycles with key_press=4'b0001 -> led=0, score=0, high_score=0, remains IDLE.
REQ-037 Start, bench LFSR model echoes correct symbols each round -> score 1,2,3; won=1; high_score=3; IDLE 2 ticks later.
REQ-038 Correct round 1, wrong key in round 2 -> lost=1, score=1, high_score=1; later 2-round game -> high_score=2.
REQ-039 No press for 5 ticks in INPUT -> lost=1; correct press on the exact expiry cycle -> accepted, no loss.
REQ-040 key_press=4'b0011 in INPUT -> lost=1 next cycle.
REQ-041 rst_n=0 during SHOW_ON after a game scoring 2 -> next cycle led=0, high_score=0, state IDLE.
